// File: rtl/sram_like_arbiter_pkg.sv
// Shared constants, ID width helper and FSM encodings for the sram-like arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_like_arbiter_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  // Width of a channel ID; never narrower than one bit so two channels still get a real field.
  function automatic int id_width(input int nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/sram_arb_id_fifo.sv
// In-order FIFO of channel IDs for accepted-but-unanswered requests.
// Latency: head valid the cycle after the push; push and pop may share a cycle.
// Backpressure: push ignored while full, pop ignored while empty (full/empty from registered count).
module sram_arb_id_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Next-state for storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Register the FIFO state; reset empties it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Merges NCH sram-like masters onto one slave port and routes responses back in order.
// Latency: zero-cycle request pass-through in IDLE; responses routed combinationally.
// Backpressure: grant held (HOLD) until m_addr_ok; no grant while the ID FIFO is full.
// Optional round-robin arbitration with `define SRAM_ARB_RR_EN (fixed priority otherwise).
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH-1:0]        ch_req,
  input  logic [NCH-1:0]        ch_wr,
  input  logic [2*NCH-1:0]      ch_size,
  input  logic [ADDR_W*NCH-1:0] ch_addr,
  input  logic [DATA_W*NCH-1:0] ch_wdata,
  output logic [NCH-1:0]        ch_addr_ok,
  output logic [NCH-1:0]        ch_data_ok,
  output logic [DATA_W-1:0]     ch_rdata,
  output logic                  m_req,
  output logic                  m_wr,
  output logic [1:0]            m_size,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic                  m_addr_ok,
  input  logic                  m_data_ok,
  input  logic [DATA_W-1:0]     m_rdata
);

  localparam int IDW = id_width(NCH);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] hold_id_q, hold_id_d;
  logic           pick_vld;
  logic [IDW-1:0] pick_id;
  logic           grant_vld;
  logic [IDW-1:0] grant_id;
  logic           fifo_full;
  logic           fifo_empty;
  logic [IDW-1:0] fifo_head;
  logic           push;
  logic           pop;

`ifdef SRAM_ARB_RR_EN
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  // Round-robin pick: first requester at or after rr_ptr, wrapping at NCH.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!pick_vld && ch_req[(int'(rr_ptr_q) + k) % NCH]) begin
        pick_vld = 1'b1;
        pick_id  = IDW'((int'(rr_ptr_q) + k) % NCH);
      end
    end
  end

  // Advance the pointer past whoever was just accepted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push) begin
      rr_ptr_d = (int'(grant_id) == NCH - 1) ? '0 : grant_id + 1'b1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`else
  // Fixed priority pick: lowest index wins (scan from the top so the lowest overwrites last).
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_req[i]) begin
        pick_vld = 1'b1;
        pick_id  = IDW'(i);
      end
    end
  end
`endif

  // Grant FSM: pass the winner straight through in IDLE, freeze it in HOLD until accepted.
  always_comb begin
    state_d   = state_q;
    hold_id_d = hold_id_q;
    grant_vld = 1'b0;
    grant_id  = hold_id_q;
    case (state_q)
      ARB_IDLE: begin
        if (!fifo_full && pick_vld) begin
          grant_vld = 1'b1;
          grant_id  = pick_id;
          if (!m_addr_ok) begin
            state_d   = ARB_HOLD;
            hold_id_d = pick_id;
          end
        end
      end
      ARB_HOLD: begin
        grant_vld = 1'b1;
        grant_id  = hold_id_q;
        if (m_addr_ok) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // FSM and held-grant registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      hold_id_q <= '0;
    end else begin
      state_q   <= state_d;
      hold_id_q <= hold_id_d;
    end
  end

  // Request side: mux the granted channel onto the slave port, zero when idle or in reset.
  always_comb begin
    m_req      = grant_vld & ~reset;
    m_wr       = 1'b0;
    m_size     = SIZE_BYTE;
    m_addr     = '0;
    m_wdata    = '0;
    ch_addr_ok = '0;
    if (m_req) begin
      m_wr    = ch_wr[grant_id];
      m_size  = ch_size[int'(grant_id)*2 +: 2];
      m_addr  = ch_addr[int'(grant_id)*ADDR_W +: ADDR_W];
      m_wdata = ch_wdata[int'(grant_id)*DATA_W +: DATA_W];
    end
    if (push) ch_addr_ok[grant_id] = 1'b1;
  end

  assign push = m_req & m_addr_ok;
  // A response with nothing outstanding is a slave protocol error and is dropped.
  assign pop  = m_data_ok & ~fifo_empty & ~reset;

  // Response side: steer data_ok to the oldest outstanding channel.
  always_comb begin
    ch_data_ok = '0;
    ch_rdata   = '0;
    if (pop) begin
      ch_data_ok[fifo_head] = 1'b1;
      ch_rdata              = m_rdata;
    end
  end

  sram_arb_id_fifo #(
    .W     (IDW),
    .DEPTH (OUTSTANDING)
  ) u_id_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (grant_id),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;

  localparam logic [31:0] A0 = 32'h1000_0040;
  localparam logic [31:0] A1 = 32'h2000_0080;
  localparam logic [31:0] W0 = 32'h0D0D_0000;
  localparam logic [31:0] W1 = 32'h1D1D_1111;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ch_req, ch_wr, ch_addr_ok, ch_data_ok;
  logic [3:0]  ch_size;
  logic [63:0] ch_addr, ch_wdata;
  logic [31:0] ch_rdata, m_addr, m_wdata, m_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [1:0]  m_size;

  logic [3:0]   q_ch_req, q_ch_wr, q_ch_addr_ok, q_ch_data_ok;
  logic [7:0]   q_ch_size;
  logic [127:0] q_ch_addr, q_ch_wdata;
  logic [31:0]  q_ch_rdata, q_m_addr, q_m_wdata, q_m_rdata;
  logic         q_m_req, q_m_wr, q_m_addr_ok, q_m_data_ok;
  logic [1:0]   q_m_size;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.NCH(2), .ADDR_W(32), .DATA_W(32), .OUTSTANDING(4)) u_dut (
    .clk(clk), .reset(reset), .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok),
    .ch_rdata(ch_rdata), .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  sram_like_arbiter #(.NCH(4), .ADDR_W(32), .DATA_W(32), .OUTSTANDING(4)) u_dut4 (
    .clk(clk), .reset(reset), .ch_req(q_ch_req), .ch_wr(q_ch_wr), .ch_size(q_ch_size),
    .ch_addr(q_ch_addr), .ch_wdata(q_ch_wdata), .ch_addr_ok(q_ch_addr_ok), .ch_data_ok(q_ch_data_ok),
    .ch_rdata(q_ch_rdata), .m_req(q_m_req), .m_wr(q_m_wr), .m_size(q_m_size), .m_addr(q_m_addr),
    .m_wdata(q_m_wdata), .m_addr_ok(q_m_addr_ok), .m_data_ok(q_m_data_ok), .m_rdata(q_m_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    ch_req = 2'b00; m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    quiet();
    q_ch_req = '0; q_m_addr_ok = 1'b0; q_m_data_ok = 1'b0; q_m_rdata = '0;
    step(); step();
    ch_req = 2'b11; m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'hFFFF_FFFF;
    #1;
    total++;
    if ({m_req, ch_addr_ok, ch_data_ok, ch_rdata} !== 37'd0) begin
      bad++;
      $display("FAIL reset_gated got=%b/%b/%b/%h exp=0", m_req, ch_addr_ok, ch_data_ok, ch_rdata);
    end
    quiet();
    step();
    reset = 1'b0;
    #1;
    total++;
    if ({m_req, m_wr, m_size, m_addr, m_wdata, ch_addr_ok, ch_data_ok, ch_rdata} !== 104'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b %b %h %h aok=%b dok=%b exp=all zero", m_req, m_wr, m_addr, m_wdata, ch_addr_ok, ch_data_ok);
    end
    step();
  endtask

  task automatic test_basic();
    ch_req = 2'b11; m_addr_ok = 1'b1;
    #1;
    total++;
    if ({m_req, ch_addr_ok, m_wr, m_size, m_addr, m_wdata} !== {1'b1, 2'b01, 1'b1, 2'd2, A0, W0}) begin
      bad++;
      $display("FAIL basic_grant0 got req=%b aok=%b wr=%b sz=%0d a=%h wd=%h exp aok=01 a=%h", m_req, ch_addr_ok, m_wr, m_size, m_addr, m_wdata, A0);
    end
    step();
    ch_req = 2'b10;
    #1;
    total++;
    if ({m_req, ch_addr_ok, m_wr, m_size, m_addr, m_wdata} !== {1'b1, 2'b10, 1'b0, 2'd1, A1, W1}) begin
      bad++;
      $display("FAIL basic_grant1 got req=%b aok=%b wr=%b sz=%0d a=%h wd=%h exp aok=10 a=%h", m_req, ch_addr_ok, m_wr, m_size, m_addr, m_wdata, A1);
    end
    step();
    quiet();
    m_data_ok = 1'b1; m_rdata = 32'hAAAA_0000;
    #1;
    total++;
    if ({ch_data_ok, ch_rdata, m_req} !== {2'b01, 32'hAAAA_0000, 1'b0}) begin
      bad++;
      $display("FAIL basic_resp0 got dok=%b rd=%h req=%b exp dok=01 rd=aaaa0000", ch_data_ok, ch_rdata, m_req);
    end
    step();
    m_rdata = 32'hBBBB_0000;
    #1;
    total++;
    if ({ch_data_ok, ch_rdata} !== {2'b10, 32'hBBBB_0000}) begin
      bad++;
      $display("FAIL basic_resp1 got dok=%b rd=%h exp dok=10 rd=bbbb0000", ch_data_ok, ch_rdata);
    end
    step();
    quiet();
  endtask

  task automatic test_hold();
    ch_req = 2'b10; m_addr_ok = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if ({m_req, ch_addr_ok, m_addr} !== {1'b1, 2'b00, A1}) begin
        bad++;
        $display("FAIL hold_cyc%0d got req=%b aok=%b a=%h exp req=1 aok=00 a=%h", c, m_req, ch_addr_ok, m_addr, A1);
      end
      step();
      ch_req = 2'b11;
    end
    m_addr_ok = 1'b1;
    #1;
    total++;
    if ({ch_addr_ok, m_addr} !== {2'b10, A1}) begin
      bad++;
      $display("FAIL hold_accept got aok=%b a=%h exp aok=10 a=%h", ch_addr_ok, m_addr, A1);
    end
    step();
    ch_req = 2'b01;
    #1;
    total++;
    if ({ch_addr_ok, m_addr} !== {2'b01, A0}) begin
      bad++;
      $display("FAIL hold_then_ch0 got aok=%b a=%h exp aok=01 a=%h", ch_addr_ok, m_addr, A0);
    end
    step();
    quiet();
    m_data_ok = 1'b1;
    #1;
    total++;
    if (ch_data_ok !== 2'b10) begin
      bad++;
      $display("FAIL hold_resp_order0 got=%b exp=10", ch_data_ok);
    end
    step();
    #1;
    total++;
    if (ch_data_ok !== 2'b01) begin
      bad++;
      $display("FAIL hold_resp_order1 got=%b exp=01", ch_data_ok);
    end
    step();
    quiet();
  endtask

  task automatic test_full();
    ch_req = 2'b01; m_addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if ({m_req, ch_addr_ok} !== 3'b101) begin
        bad++;
        $display("FAIL full_fill%0d got req=%b aok=%b exp req=1 aok=01", k, m_req, ch_addr_ok);
      end
      step();
    end
    #1;
    total++;
    if ({m_req, ch_addr_ok} !== 3'b000) begin
      bad++;
      $display("FAIL full_block got req=%b aok=%b exp req=0 aok=00", m_req, ch_addr_ok);
    end
    step();
    m_data_ok = 1'b1; m_rdata = 32'h5555_0001;
    #1;
    total++;
    if ({m_req, ch_addr_ok, ch_data_ok, ch_rdata} !== {1'b0, 2'b00, 2'b01, 32'h5555_0001}) begin
      bad++;
      $display("FAIL full_pop_no_push got req=%b aok=%b dok=%b rd=%h exp req=0 aok=00 dok=01", m_req, ch_addr_ok, ch_data_ok, ch_rdata);
    end
    step();
    m_data_ok = 1'b0;
    #1;
    total++;
    if ({m_req, ch_addr_ok} !== 3'b101) begin
      bad++;
      $display("FAIL full_retry got req=%b aok=%b exp req=1 aok=01", m_req, ch_addr_ok);
    end
    step();
    quiet();
    m_data_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if (ch_data_ok !== 2'b01) begin
        bad++;
        $display("FAIL full_drain%0d got=%b exp=01", k, ch_data_ok);
      end
      step();
    end
    #1;
    total++;
    if ({ch_data_ok, ch_rdata} !== 34'd0) begin
      bad++;
      $display("FAIL empty_resp got dok=%b rd=%h exp dok=00 rd=0", ch_data_ok, ch_rdata);
    end
    step();
    quiet();
  endtask

  task automatic test_wrap();
    int          exp_q[$];
    int          c;
    int          hd;
    logic [1:0]  eo, ed;
    logic [9:0]  pat;
    pat = 10'b1001011010;
    for (int k = 0; k < 3; k++) begin
      c = (k == 1) ? 0 : 1;
      ch_req = (c == 1) ? 2'b10 : 2'b01; m_addr_ok = 1'b1; m_data_ok = 1'b0;
      exp_q.push_back(c);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      c = int'(pat[i]);
      ch_req = (c == 1) ? 2'b10 : 2'b01; m_addr_ok = 1'b1; m_data_ok = 1'b1;
      m_rdata = 32'hC0DE_0000 + 32'(i);
      hd = exp_q.pop_front();
      exp_q.push_back(c);
      eo = (c == 1) ? 2'b10 : 2'b01;
      ed = (hd == 1) ? 2'b10 : 2'b01;
      #1;
      total++;
      if ({m_req, ch_addr_ok, ch_data_ok, ch_rdata} !== {1'b1, eo, ed, 32'hC0DE_0000 + 32'(i)}) begin
        bad++;
        $display("FAIL wrap%0d got req=%b aok=%b dok=%b rd=%h exp req=1 aok=%b dok=%b", i, m_req, ch_addr_ok, ch_data_ok, ch_rdata, eo, ed);
      end
      step();
    end
    quiet();
    m_data_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      hd = exp_q.pop_front();
      ed = (hd == 1) ? 2'b10 : 2'b01;
      #1;
      total++;
      if (ch_data_ok !== ed) begin
        bad++;
        $display("FAIL wrap_drain%0d got=%b exp=%b", k, ch_data_ok, ed);
      end
      step();
    end
    quiet();
  endtask

  task automatic test_reset_mid();
    ch_req = 2'b01; m_addr_ok = 1'b1;
    step(); step(); step();
    ch_req = 2'b10; m_addr_ok = 1'b0;
    step();
    quiet();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_data_ok = 1'b1; m_rdata = 32'h1234_5678;
    #1;
    total++;
    if ({m_req, m_addr, ch_addr_ok, ch_data_ok, ch_rdata} !== 69'd0) begin
      bad++;
      $display("FAIL rst_mid_outputs got req=%b a=%h aok=%b dok=%b rd=%h exp all zero", m_req, m_addr, ch_addr_ok, ch_data_ok, ch_rdata);
    end
    step();
    quiet();
    ch_req = 2'b01; m_addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if ({ch_addr_ok, m_addr} !== {2'b01, A0}) begin
        bad++;
        $display("FAIL rst_mid_refill%0d got aok=%b a=%h exp aok=01 a=%h", k, ch_addr_ok, m_addr, A0);
      end
      step();
    end
    quiet();
    m_data_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if (ch_data_ok !== 2'b01) begin
        bad++;
        $display("FAIL rst_mid_drain%0d got=%b exp=01", k, ch_data_ok);
      end
      step();
    end
    quiet();
  endtask

  task automatic test_rr();
    int         ex;
    logic [3:0] eo;
    q_ch_req = 4'hF; q_m_addr_ok = 1'b1; q_m_data_ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
`ifdef SRAM_ARB_RR_EN
      ex = k % 4;
`else
      ex = 0;
`endif
      eo = 4'b0001 << ex;
      #1;
      total++;
      if ({q_ch_addr_ok, q_m_addr} !== {eo, q_ch_addr[ex*32 +: 32]}) begin
        bad++;
        $display("FAIL rr_grant%0d got aok=%b a=%h exp aok=%b", k, q_ch_addr_ok, q_m_addr, eo);
      end
      step();
    end
    q_ch_req = '0; q_m_addr_ok = 1'b0; q_m_data_ok = 1'b0;
  endtask

  initial begin
    ch_wr    = 2'b01;
    ch_size  = {2'd1, 2'd2};
    ch_addr  = {A1, A0};
    ch_wdata = {W1, W0};
    q_ch_wr    = 4'b0000;
    q_ch_size  = 8'hAA;
    q_ch_addr  = {32'h4000_0300, 32'h4000_0200, 32'h4000_0100, 32'h4000_0000};
    q_ch_wdata = '0;
    test_reset();
    test_basic();
    test_hold();
    test_full();
    test_wrap();
    test_reset_mid();
    test_rr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Merges NCH sram-like master channels onto one shared sram-like slave port. Channel 0 is the data side, channel 1 the instruction side.
- Sits between the 5-stage core (IF/EXE/MEM) and the AXI bridge.
- Tracks outstanding requests in an in-order ID FIFO so that each data_ok/rdata returns to the channel that issued it.
- Successor of the fixed two-SRAM core top interface: parametrised channel count and outstanding depth, split address/data handshakes.

Parameters:
- NCH, 2, number of master channels (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- OUTSTANDING, 4, max accepted-but-unanswered requests (power of two, >=2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ch_req  in  NCH  per-channel request valid
- ch_wr  in  NCH  per-channel write flag
- ch_size  in  2*NCH  per-channel size (0=byte, 1=half, 2=word)
- ch_addr  in  ADDR_W*NCH  per-channel address, channel i at slice [i*ADDR_W +: ADDR_W]
- ch_wdata  in  DATA_W*NCH  per-channel write data
- ch_addr_ok  out  NCH  request accepted, one-hot or zero
- ch_data_ok  out  NCH  response for channel, one-hot or zero
- ch_rdata  out  DATA_W  read data, shared and valid with ch_data_ok
- m_req  out  1  slave request valid
- m_wr  out  1  slave write flag
- m_size  out  2  slave size
- m_addr  out  ADDR_W  slave address
- m_wdata  out  DATA_W  slave write data
- m_addr_ok  in  1  slave accepted request
- m_data_ok  in  1  slave response valid
- m_rdata  in  DATA_W  slave read data

Behaviour:
- Reset values:
  - All outputs 0.
  - FIFO empty, count=0.
  - Grant register idle.
  - Round-robin pointer (if enabled) = 0.
- States: IDLE, HOLD.
  - IDLE:
    - If FIFO not full and any ch_req: pick a winner (fixed priority, lowest index wins).
    - Drive m_* combinationally from the winner's inputs in the same cycle (zero-cycle latency).
    - If m_addr_ok the same cycle: stay IDLE. Otherwise latch the winner ID and go to HOLD.
  - HOLD:
    - Grant frozen to the latched ID; m_req=1 with that channel's signals.
    - Other channels' requests are ignored.
    - On m_addr_ok: go to IDLE.
- The granted channel must keep req and its payload stable until addr_ok. The arbiter does not re-sample other channels during HOLD.
- Address handshake:
  - ch_addr_ok[winner] = m_addr_ok & m_req; all other ch_addr_ok bits = 0.
  - Each accepted request pushes the winner ID (clog2(NCH) bits) into the ID FIFO.
- Response routing:
  - On m_data_ok: ch_data_ok[head]=1, ch_rdata=m_rdata (combinational), pop the FIFO.
  - Write responses are routed the same way as reads.
- FIFO full (count==OUTSTANDING):
  - m_req=0 in IDLE.
  - A pop in the same cycle does NOT enable a push; the push is retried next cycle.
- HOLD with FIFO full cannot occur: a request is only granted while count<OUTSTANDING.
- Simultaneous push and pop: count unchanged; head and tail both advance. Pointers wrap modulo OUTSTANDING.
- m_data_ok with FIFO empty: protocol error. Ignored, all ch_data_ok=0, count stays 0.
- Reset mid-transaction: FIFO, grant and state are cleared. Responses from the slave after reset are ignored as on empty.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - Search starts at rr_ptr.
  - After each accepted request, rr_ptr = winner+1, wrapping at NCH.
- Undefined: fixed priority (channel 0 highest); no rr_ptr register exists.

Decomposition:
- Shared package/header holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD constants.
  - The ID width function clog2(NCH).
  - State encodings ARB_IDLE/ARB_HOLD.
- Sub-module: sram_arb_id_fifo, a parametrised sync FIFO with width clog2(NCH), depth OUTSTANDING, push/pop/full/empty/head outputs.

Test Plan:
1. Basic routing: NCH=2. ch_req=2'b11, m_addr_ok=1 in the same cycle -> ch_addr_ok=2'b01. ch1 is granted next cycle. Then m_data_ok twice with rdata 0xAAAA0000, 0xBBBB0000 -> ch_data_ok=01 then 10, with matching rdata.
2. Hold: ch1 req, m_addr_ok=0 for 3 cycles, ch0 req raised at cycle 1 -> m_addr stays ch1's address, no ch0 grant until ch1 is accepted.
3. Full: OUTSTANDING=4. Accept 4 requests, no data_ok -> m_req=0 and all ch_addr_ok=0. In a cycle with data_ok and a pending req -> no push that cycle, accepted next cycle.
4. Wrap: 10 accept/response pairs interleaved with simultaneous push/pop -> IDs are returned in order, count never exceeds 4.
5. Error and reset: m_data_ok with FIFO empty -> ch_data_ok=0. Reset asserted with 3 outstanding -> next cycle count=0 and outputs are 0.
6. SRAM_ARB_RR_EN: NCH=4, all four requesting with addr_ok always 1 -> grants in order 0,1,2,3,0. Without the macro -> always 0.
